// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetch with in-flight address queue, IF/ID output FIFO and redirect drop counting.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] pc_q, pc_d;
  logic [31:0] aq_q [DEPTH];
  logic [63:0] fq_q [DEPTH];
  logic [AW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d, f_wr_q, f_wr_d, f_rd_q, f_rd_d;
  logic [CW-1:0] aq_cnt_q, aq_cnt_d, f_cnt_q, f_cnt_d, drop_q, drop_d;
  logic [CW:0] credit;
  logic acc, dropping, push, pop;
  // Buffered plus in-flight words never exceed DEPTH, so the FIFO cannot overflow.
  assign credit         = {1'b0, aq_cnt_q} + {1'b0, f_cnt_q};
  assign imem_req_valid = !rst && (credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign acc            = imem_req_valid && imem_req_ready;
  assign dropping       = drop_q != '0;
  assign push           = imem_resp_valid && !dropping && !redirect_valid;
  assign out_valid      = !rst && (f_cnt_q != '0);
  assign pop            = out_valid && out_ready;
  assign out_instr      = out_valid ? fq_q[f_rd_q][63:32] : '0;
  assign out_pc_4       = out_valid ? fq_q[f_rd_q][31:0] : '0;
  always_comb begin
    pc_d     = redirect_valid ? (redirect_pc & ~32'd3) : acc ? pc_q + 32'd4 : pc_q;
    aq_wr_d  = acc ? aq_wr_q + AW'(1) : aq_wr_q;
    aq_rd_d  = imem_resp_valid ? aq_rd_q + AW'(1) : aq_rd_q;
    aq_cnt_d = aq_cnt_q + CW'(acc) - CW'(imem_resp_valid);
    drop_d   = redirect_valid ? aq_cnt_d : drop_q - CW'(imem_resp_valid && dropping);
    f_wr_d   = redirect_valid ? '0 : push ? f_wr_q + AW'(1) : f_wr_q;
    f_rd_d   = redirect_valid ? '0 : pop ? f_rd_q + AW'(1) : f_rd_q;
    f_cnt_d  = redirect_valid ? '0 : f_cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      aq_wr_q  <= '0;
      aq_rd_q  <= '0;
      aq_cnt_q <= '0;
      f_wr_q   <= '0;
      f_rd_q   <= '0;
      f_cnt_q  <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      aq_wr_q  <= aq_wr_d;
      aq_rd_q  <= aq_rd_d;
      aq_cnt_q <= aq_cnt_d;
      f_wr_q   <= f_wr_d;
      f_rd_q   <= f_rd_d;
      f_cnt_q  <= f_cnt_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) aq_q[aq_wr_q] <= pc_q;
    if (push) fq_q[f_wr_q] <= {imem_resp_data, aq_q[aq_rd_q] + 32'd4};
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a queue-based memory model (DEPTH 2 and DEPTH 4 instances).
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, req_ready, out_ready, redirect, hold, both0;
  logic nored = 1'b0;
  logic [31:0] redirect_pc;
  logic [31:0] zpc = 32'h0;
  logic rv0, sv0, ov0, rv1, sv1, ov1;
  logic [31:0] ra0, sd0, oi0, op0, ra1, sd1, oi1, op1;
  logic [7:0] tag;
  logic [31:0] q0[$], q1[$], reqs0[$], outs0[$], outi0[$], reqs1[$], outs1[$], outi1[$];
  int n_chk = 0, n_pass = 0;
  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u0 (
    .clk(clk), .rst(rst), .imem_req_valid(rv0), .imem_req_ready(req_ready), .imem_req_addr(ra0),
    .imem_resp_valid(sv0), .imem_resp_data(sd0), .redirect_valid(redirect), .redirect_pc(redirect_pc),
    .out_valid(ov0), .out_ready(out_ready), .out_instr(oi0), .out_pc_4(op0));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .imem_req_valid(rv1), .imem_req_ready(req_ready), .imem_req_addr(ra1),
    .imem_resp_valid(sv1), .imem_resp_data(sd1), .redirect_valid(nored), .redirect_pc(zpc),
    .out_valid(ov1), .out_ready(out_ready), .out_instr(oi1), .out_pc_4(op1));
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", t, got, exp);
  endtask
  // One clock: memory answers from its queue, sample mid-cycle, then update the model at the edge.
  task automatic step();
    logic a0, a1;
    logic [31:0] aa0, aa1;
    sv0 = !hold && q0.size() > 0;
    sd0 = sv0 ? q0[0] : 32'h0;
    sv1 = !hold && q1.size() > 0;
    sd1 = sv1 ? q1[0] : 32'h0;
    #3;
    a0 = rv0 && req_ready;
    a1 = rv1 && req_ready;
    aa0 = ra0;
    aa1 = ra1;
    both0 = a0 && sv0;
    if (a0) reqs0.push_back(aa0);
    if (a1) reqs1.push_back(aa1);
    if (ov0 && out_ready) begin outs0.push_back(op0); outi0.push_back(oi0); end
    if (ov1 && out_ready) begin outs1.push_back(op1); outi1.push_back(oi1); end
    @(posedge clk);
    if (sv0) void'(q0.pop_front());
    if (sv1) void'(q1.pop_front());
    if (a0) q0.push_back(aa0 ^ {tag, 24'h0});
    if (a1) q1.push_back(aa1 ^ {tag, 24'h0});
    #1;
  endtask
  task automatic reset_dut(input int n);
    rst = 1'b1;
    hold = 1'b0;
    redirect = 1'b0;
    #1;
    chk("rst_req_valid", 32'(rv0), 32'h0);
    chk("rst_out_valid1", 32'(ov1), 32'h0);
    repeat (n) step();
    rst = 1'b0;
    tag++;
    reqs0.delete(); outs0.delete(); outi0.delete();
    reqs1.delete(); outs1.delete(); outi1.delete();
    #1;
    chk("post_out_valid0", 32'(ov0), 32'h0);
    chk("post_out_valid1", 32'(ov1), 32'h0);
    chk("post_instr", oi0, 32'h0);
    chk("post_pc4", op0, 32'h0);
    chk("first_req_valid", 32'(rv0), 32'h1);
    chk("first_addr0", ra0, 32'h0);
    chk("first_addr1", ra1, 32'hFFFF_FFF8);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int bad;
    rst = 1'b1; req_ready = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    hold = 1'b0; tag = 8'h0; sv0 = 1'b0; sd0 = 32'h0; sv1 = 1'b0; sd1 = 32'h0; both0 = 1'b0;
    @(posedge clk);
    #1;
    reset_dut(4);
    repeat (8) step();
    chk("seq_req0", reqs0[0], 32'h0);
    chk("seq_req1", reqs0[1], 32'h4);
    chk("seq_req2", reqs0[2], 32'h8);
    chk("seq_pc4_0", outs0[0], 32'h4);
    chk("seq_pc4_1", outs0[1], 32'h8);
    chk("seq_pc4_2", outs0[2], 32'hC);
    chk("seq_instr0", outi0[0], 32'h0 ^ {tag, 24'h0});
    chk("tput_reqs", reqs1.size(), 32'd8);
    chk("tput_outs", outs1.size(), 32'd6);
    chk("wrap_req2", reqs1[2], 32'h0);
    chk("wrap_pc4_0", outs1[0], 32'hFFFF_FFFC);
    chk("wrap_pc4_1", outs1[1], 32'h0);
    chk("wrap_pc4_2", outs1[2], 32'h4);
    reset_dut(5);
    out_ready = 1'b0;
    repeat (6) step();
    chk("stall_reqs", reqs0.size(), 32'd2);
    chk("stall_req_valid", 32'(rv0), 32'h0);
    chk("stall_out_valid", 32'(ov0), 32'h1);
    chk("stall_pc4", op0, 32'h4);
    out_ready = 1'b1;
    repeat (10) step();
    chk("resume_addr", reqs0[2], 32'h8);
    bad = 0;
    foreach (outs0[i]) if (outs0[i] != 32'(4 * (i + 1))) bad++;
    chk("resume_order", bad, 32'd0);
    chk("resume_count", 32'(outs0.size() >= 4), 32'h1);
    reset_dut(5);
    req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0; req_ready = 1'b1; hold = 1'b1;
    repeat (3) step();
    chk("redir_inflight", reqs0.size(), 32'd2);
    chk("redir_req0", reqs0[0], 32'h10);
    chk("redir_req1", reqs0[1], 32'h14);
    redirect = 1'b1; redirect_pc = 32'h203;
    reqs0.delete(); outs0.delete(); outi0.delete();
    step();
    redirect = 1'b0; hold = 1'b0;
    repeat (8) step();
    chk("redir_new_addr", reqs0[0], 32'h200);
    chk("redir_pc4", outs0[0], 32'h204);
    chk("redir_instr", outi0[0], 32'h200 ^ {tag, 24'h0});
    reset_dut(5);
    step();
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    chk("sim_acc_resp", 32'(both0), 32'h1);
    redirect = 1'b0;
    repeat (8) step();
    chk("sim_req1", reqs0[1], 32'h4);
    chk("sim_req2", reqs0[2], 32'h300);
    chk("sim_first_pc4", outs0[0], 32'h304);
    chk("sim_first_instr", outi0[0], 32'h300 ^ {tag, 24'h0});
    reset_dut(5);
    hold = 1'b1; out_ready = 1'b0;
    repeat (3) step();
    req_ready = 1'b0; hold = 1'b0;
    step();
    hold = 1'b1;
    chk("pre_rst_buffered", 32'(ov1), 32'h1);
    chk("pre_rst_inflight", q1.size(), 32'd2);
    reset_dut(5);
    req_ready = 1'b1; out_ready = 1'b1;
    repeat (6) step();
    chk("rst_mid_req", reqs1[0], 32'hFFFF_FFF8);
    chk("rst_mid_pc4", outs1[0], 32'hFFFF_FFFC);
    chk("rst_mid_instr", outi1[0], 32'hFFFF_FFF8 ^ {tag, 24'h0});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 Parameter: DEPTH, default 2, maximum instructions held or in flight; legal values 2 and 4.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 imem_req_valid  out  1  fetch request present.
REQ-006 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  out  32  word-aligned fetch address.
REQ-008 imem_resp_valid  in  1  instruction word returned, in request order, with no backpressure.
REQ-009 imem_resp_data  in  32  returned instruction.
REQ-010 redirect_valid  in  1  branch or jump taken; restart fetch.
REQ-011 redirect_pc  in  32  new fetch address; bits [1:0] SHALL be ignored and treated as 0.
REQ-012 out_valid  out  1  instruction available to decode (the IF/ID latch).
REQ-013 out_ready  in  1  decode accepts this cycle; a transfer is out_valid && out_ready.
REQ-014 out_instr  out  32  instruction word.
REQ-015 out_pc_4  out  32  fetch address of out_instr + 4.

Function
REQ-016 Internal state SHALL be: pc; an address queue of DEPTH entries holding in-flight addresses; an output FIFO of DEPTH entries holding {instr, pc_4}; and drop_cnt.
REQ-017 Credit rule: imem_req_valid SHALL be 1 iff in_flight + fifo_count < DEPTH and rst = 0; consequently the output FIFO SHALL never overflow.
REQ-018 imem_req_addr SHALL equal pc; pc and addr SHALL hold stable while imem_req_valid && !imem_req_ready, except on redirect.
REQ-019 On request acceptance (imem_req_valid && imem_req_ready), the block SHALL push pc to the address queue and set pc <= pc + 4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 On imem_resp_valid with drop_cnt = 0, the block SHALL pop the address queue and push {imem_resp_data, addr + 4} to the output FIFO, with addr + 4 computed mod 2^32.
REQ-021 Latency: a response in cycle N SHALL appear on out_valid/out_instr in cycle N+1 at the earliest; there is no combinational path from imem_resp_* to out_*.
REQ-022 Outputs SHALL be presented in fetch order; out_instr/out_pc_4 SHALL hold stable while out_valid && !out_ready.
REQ-023 Simultaneous output FIFO push and pop SHALL both occur, with occupancy unchanged; when the FIFO is empty out_valid SHALL be 0.
REQ-024 Redirect (redirect_valid = 1) SHALL have the following effects on the next edge:
  - pc <= {redirect_pc[31:2], 2'b00};
  - the output FIFO is flushed;
  - drop_cnt <= number of requests in flight after this cycle, including one accepted this cycle and excluding a response arriving this cycle;
  - the address queue is not altered except by this cycle's accept or response.
REQ-025 A response arriving in the same cycle as a redirect SHALL be discarded.
REQ-026 While drop_cnt > 0, each imem_resp_valid SHALL pop the address queue, decrement drop_cnt, and push nothing.
REQ-027 A transfer completing in the same cycle as a redirect SHALL count as delivered; out_valid SHALL be 0 in the following cycle unless new data has been pushed.
REQ-028 imem_req_valid in the redirect cycle SHALL still follow REQ-017 using the pre-redirect pc.
REQ-029 A redirect while drop_cnt > 0 SHALL reload drop_cnt per REQ-024; the count SHALL never underflow.
REQ-030 imem_resp_valid with no request in flight is illegal; behaviour is unspecified, and the bench SHALL flag it as an error.

Reset
REQ-031 When rst = 1 at an edge, the block SHALL set pc <= RESET_PC, empty both queues and set drop_cnt <= 0; out_valid and imem_req_valid SHALL read 0 during the rst cycle.
REQ-032 The first request SHALL be at RESET_PC in the first cycle after rst deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight and buffered instructions; responses for pre-reset requests SHALL NOT be delivered. The bench SHALL hold rst for a period longer than the memory latency.
REQ-034 out_instr and out_pc_4 SHALL be 0 after reset.

Verification
REQ-035 Reset, memory always ready with 1-cycle latency, out_ready = 1 -> addrs 0, 4, 8 issued back-to-back; out_pc_4 = 4, 8, 12 in order; steady-state throughput 1 per cycle.
REQ-036 out_ready = 0 with DEPTH = 2 -> exactly 2 requests issued, then imem_req_valid = 0; raising out_ready resumes fetch at addr 8 with no loss or duplication.
REQ-037 Two requests in flight (addrs 0x10, 0x14), redirect_valid with redirect_pc = 0x203 -> both responses dropped; next request addr 0x200; first output out_pc_4 = 0x204.
REQ-038 RESET_PC = 32'hFFFF_FFF8 -> requests at FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc_4 = FFFF_FFFC, 0000_0000, 0000_0004.
REQ-039 Redirect in the same cycle as request acceptance and a response arrival -> accepted request and arriving response both dropped; drop_cnt correct; no stale instruction is output.
REQ-040 rst asserted with 2 requests in flight and 1 buffered instruction -> out_valid = 0 next cycle; no stale output after release; first request at RESET_PC.
